// File: rtl/param_piso_if.sv
// Handshake bundle for param_piso: parallel word in, serial bit stream out.
// The slave modport is the serialiser's view; the master modport is the sender/consumer side.
interface param_piso_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] parallel_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic              serial_o;
    logic              valid_o;
    logic              last_o;
    logic              out_ready_i;
    logic              empty_o;

    modport slave (
        input  parallel_i, in_valid_i, out_ready_i,
        output in_ready_o, serial_o, valid_o, last_o, empty_o
    );

    modport master (
        output parallel_i, in_valid_i, out_ready_i,
        input  in_ready_o, serial_o, valid_o, last_o, empty_o
    );
endinterface

// File: rtl/param_piso.sv
// Parallel-in serial-out shifter with valid/ready on both sides.
// A new word may be accepted on the same edge the final bit of the previous word is consumed.
module param_piso #(
    parameter int DATA_W    = 8,
    parameter int MSB_FIRST = 0
) (
    input  logic         clk,
    input  logic         reset,
    param_piso_if.slave  bus
);
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic {
        EMPTY = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid, last_bit, xfer, accept;

    assign valid    = (state_q == SHIFT);
    assign last_bit = valid && (cnt_q == CNT_W'(DATA_W - 1));
    assign xfer     = valid && bus.out_ready_i;
    assign accept   = bus.in_valid_i && bus.in_ready_o;

    assign bus.valid_o    = valid;
    assign bus.empty_o    = !valid;
    assign bus.last_o     = last_bit;
    assign bus.in_ready_o = !valid || (last_bit && bus.out_ready_i);
    assign bus.serial_o   = valid && ((MSB_FIRST != 0) ? shreg_q[DATA_W-1] : shreg_q[0]);

    // The presented bit always sits at one end of the register; zero-fill keeps it clean when drained.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (accept) begin
            shreg_d = bus.parallel_i;
            cnt_d   = '0;
        end else if (xfer) begin
            shreg_d = (MSB_FIRST != 0) ? {shreg_q[DATA_W-2:0], 1'b0}
                                       : {1'b0, shreg_q[DATA_W-1:1]};
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            case (state_q)
                EMPTY: if (accept) state_q <= SHIFT;
                SHIFT: if (last_bit && xfer && !accept) state_q <= EMPTY;
                default: state_q <= EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_param_piso.sv
// Bench for param_piso: LSB-first and MSB-first instances share stimulus; a bit-queue model checks every cycle.
module tb_param_piso;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] par;
    logic         in_valid;
    logic         out_ready;

    int total = 0;
    int bad   = 0;

    param_piso_if #(.DATA_W(W)) b0 ();
    param_piso_if #(.DATA_W(W)) b1 ();

    assign b0.parallel_i  = par;
    assign b0.in_valid_i  = in_valid;
    assign b0.out_ready_i = out_ready;
    assign b1.parallel_i  = par;
    assign b1.in_valid_i  = in_valid;
    assign b1.out_ready_i = out_ready;

    param_piso #(.DATA_W(W), .MSB_FIRST(0)) u_lsb (.clk(clk), .reset(reset), .bus(b0));
    param_piso #(.DATA_W(W), .MSB_FIRST(1)) u_msb (.clk(clk), .reset(reset), .bus(b1));

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: each instance is a queue of pending bits in emission order.
    bit q0[$];
    bit q1[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q0.delete();
            q1.delete();
        end else begin
            bit v0, r0, v1, r1;
            v0 = q0.size() > 0;
            r0 = !v0 || (q0.size() == 1 && out_ready);
            v1 = q1.size() > 0;
            r1 = !v1 || (q1.size() == 1 && out_ready);
            if (v0 && out_ready) void'(q0.pop_front());
            if (v1 && out_ready) void'(q1.pop_front());
            if (in_valid && r0) for (int i = 0; i < W; i++) q0.push_back(par[i]);
            if (in_valid && r1) for (int i = W - 1; i >= 0; i--) q1.push_back(par[i]);
        end
    end

    always @(negedge clk) begin
        bit v;
        v = q0.size() > 0;
        check("lsb_valid", b0.valid_o, v);
        check("lsb_empty", b0.empty_o, !v);
        check("lsb_serial", b0.serial_o, v ? q0[0] : 1'b0);
        check("lsb_last", b0.last_o, v && q0.size() == 1);
        check("lsb_in_ready", b0.in_ready_o, !v || (q0.size() == 1 && out_ready));
        v = q1.size() > 0;
        check("msb_valid", b1.valid_o, v);
        check("msb_empty", b1.empty_o, !v);
        check("msb_serial", b1.serial_o, v ? q1[0] : 1'b0);
        check("msb_last", b1.last_o, v && q1.size() == 1);
        check("msb_in_ready", b1.in_ready_o, !v || (q1.size() == 1 && out_ready));
    end

    // Transfer log for hand-computed stream checks; first emitted bit ends up most significant.
    logic [63:0] log0, log1, last0;
    int n0, nv, nr, ne;

    task automatic clr();
        log0 = '0; log1 = '0; last0 = '0;
        n0 = 0; nv = 0; nr = 0; ne = 0;
    endtask

    task automatic cyc();
        @(negedge clk);
        if (b0.valid_o && b0.out_ready_i) begin
            log0  = {log0[62:0], b0.serial_o};
            last0 = {last0[62:0], b0.last_o};
            n0++;
        end
        if (b1.valid_o && b1.out_ready_i) log1 = {log1[62:0], b1.serial_o};
        if (b0.valid_o)    nv++;
        if (b0.in_ready_o) nr++;
        if (b0.empty_o)    ne++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; par = '0; in_valid = 1'b0; out_ready = 1'b1;
        clr();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", b0.valid_o, 1'b0);
        check("rst_empty", b0.empty_o, 1'b1);
        check("rst_in_ready", b0.in_ready_o, 1'b1);
        check("rst_serial", b0.serial_o, 1'b0);
        check("rst_last", b1.last_o, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 0xC1, both bit orders, latency 1
        clr();
        par = 8'hC1; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        check("c1_latency_valid", b0.valid_o, 1'b1);
        check("c1_first_lsb", b0.serial_o, 1'b1);
        check("c1_first_msb", b1.serial_o, 1'b1);
        repeat (10) cyc();
        check("c1_count", n0, 8);
        check("c1_lsb_stream", log0[7:0], 8'b1000_0011);
        check("c1_msb_stream", log1[7:0], 8'b1100_0001);
        check("c1_last_pos", last0[7:0], 8'b0000_0001);
        check("c1_empty_after", b0.empty_o, 1'b1);

        // 0x0F then 0xF0 back to back
        par = 8'h0F; in_valid = 1'b1;
        cyc();
        par = 8'hF0;
        clr();
        repeat (8) cyc();
        in_valid = 1'b0;
        repeat (8) cyc();
        check("b2b_valid_cycles", nv, 16);
        check("b2b_ready_cycles", nr, 2);
        check("b2b_empty_cycles", ne, 0);
        check("b2b_lsb_stream", log0[15:0], 16'hF00F);
        check("b2b_msb_stream", log1[15:0], 16'h0FF0);
        repeat (2) cyc();

        // 0xA5 with a 3-cycle stall after the 2nd bit
        par = 8'hA5; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        clr();
        repeat (2) cyc();
        out_ready = 1'b0;
        repeat (3) cyc();
        check("stall_count", n0, 2);
        check("stall_valid", b0.valid_o, 1'b1);
        check("stall_serial", b0.serial_o, 1'b1);
        check("stall_last", b0.last_o, 1'b0);
        out_ready = 1'b1;
        repeat (8) cyc();
        check("stall_total", n0, 8);
        check("stall_lsb_stream", log0[7:0], 8'b1010_0101);
        check("stall_msb_stream", log1[7:0], 8'b1010_0101);

        // 0xFF offered mid-word while 0x01 shifts
        par = 8'h01; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        clr();
        repeat (3) cyc();
        par = 8'hFF; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        repeat (6) cyc();
        check("ign_count", n0, 8);
        check("ign_lsb_stream", log0[7:0], 8'b1000_0000);
        check("ign_msb_stream", log1[7:0], 8'b0000_0001);
        check("ign_empty", b0.empty_o, 1'b1);

        // reset mid-word, then a fresh 0x81
        par = 8'hFF; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        clr();
        repeat (3) cyc();
        check("pre_rst_bits", log0[2:0], 3'b111);
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", b0.valid_o, 1'b0);
        check("arst_empty", b0.empty_o, 1'b1);
        check("arst_serial", b0.serial_o, 1'b0);
        check("arst_in_ready", b1.in_ready_o, 1'b1);
        par = 8'h3C; in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("rst_edge_no_accept", b0.valid_o, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        clr();
        par = 8'h81; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        repeat (10) cyc();
        check("post_rst_count", n0, 8);
        check("post_rst_lsb", log0[7:0], 8'b1000_0001);
        check("post_rst_msb", log1[7:0], 8'b1000_0001);
        check("post_rst_empty", b1.empty_o, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/param_piso.md
PARAM_PISO -- requirements
Module: param_piso

Interface
REQ-001 SHALL have parameter DATA_W, default 8: parallel word width in bits; legal range 2..64.
REQ-002 SHALL have parameter MSB_FIRST, default 0: 0 = bit 0 shifted out first, 1 = bit DATA_W-1 shifted out first.
REQ-003 SHALL have port clk, input, 1: single clock, all state on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port parallel_i, input, DATA_W: parallel word to serialise.
REQ-006 SHALL have port in_valid_i, input, 1: parallel_i holds a word to load.
REQ-007 SHALL have port in_ready_o, output, 1: block accepts a word this cycle.
REQ-008 SHALL have port serial_o, output, 1: current serial bit.
REQ-009 SHALL have port valid_o, output, 1: serial_o carries a data bit.
REQ-010 SHALL have port last_o, output, 1: serial_o is the final bit of the word.
REQ-011 SHALL have port out_ready_i, input, 1: downstream consumes serial_o this cycle.
REQ-012 SHALL have port empty_o, output, 1: no word loaded; no bits pending.

Function
REQ-013 SHALL treat a word as accepted on a rising edge where in_valid_i and in_ready_o are both 1; parallel_i is captured into a DATA_W-bit shift register.
REQ-014 SHALL drive in_ready_o = empty_o OR (valid_o AND last_o AND out_ready_i), combinationally; this permits back-to-back words with no idle bit.
REQ-015 SHALL ignore in_valid_i and parallel_i while in_ready_o is 0; a dropped word is the sender's responsibility.
REQ-016 SHALL treat a bit as transferred on a rising edge where valid_o and out_ready_i are both 1.
REQ-017 SHALL hold serial_o, valid_o, last_o and the internal state unchanged while valid_o=1 and out_ready_i=0.
REQ-018 SHALL present the first bit of an accepted word on serial_o with valid_o=1 in the cycle after acceptance (latency 1 cycle).
REQ-019 SHALL present bits in order 0..DATA_W-1 when MSB_FIRST=0 and DATA_W-1..0 when MSB_FIRST=1; one bit advances per transfer.
REQ-020 SHALL count transferred bits in a counter of $clog2(DATA_W) bits; it resets to 0 on load and increments once per transfer.
REQ-021 SHALL assert last_o exactly when valid_o=1 and the counter equals DATA_W-1.
REQ-022 SHALL, on a last-bit transfer with no simultaneous acceptance, return to EMPTY: valid_o=0, last_o=0, serial_o=0, empty_o=1 in the next cycle.
REQ-023 SHALL, on a last-bit transfer with a simultaneous acceptance, load the new word and continue with valid_o=1 and its first bit in the next cycle, with no gap.
REQ-024 SHALL implement two states, EMPTY (empty_o=1, valid_o=0) and SHIFT (empty_o=0, valid_o=1); EMPTY->SHIFT on acceptance, SHIFT->EMPTY on a last-bit transfer without acceptance, else hold.
REQ-025 SHALL force serial_o=0 whenever valid_o=0.
REQ-026 SHALL keep empty_o the exact complement of valid_o in all cycles.

Reset
REQ-027 SHALL, while reset=1, asynchronously force: state EMPTY, shift register 0, counter 0, serial_o=0, valid_o=0, last_o=0, empty_o=1, in_ready_o=1.
REQ-028 SHALL abort an in-progress word on reset assertion without emitting further bits; after release, the first acceptance starts a fresh word.
REQ-029 SHALL make no acceptance or transfer on the rising edge that coincides with reset=1.

Verification
REQ-030 SHALL cover: DATA_W=8, MSB_FIRST=0, out_ready_i=1, load 0xC1 -> serial_o 1,0,0,0,0,0,1,1 on 8 consecutive valid cycles, last_o only on the 8th, then empty_o=1.
REQ-031 SHALL cover: DATA_W=8, MSB_FIRST=1, load 0xC1 -> serial_o 1,1,0,0,0,0,0,1; first bit appears 1 cycle after acceptance.
REQ-032 SHALL cover: in_valid_i held 1 with 0x0F then 0xF0 (LSB first) -> 16 contiguous valid_o cycles 1,1,1,1,0,0,0,0,0,0,0,0,1,1,1,1; in_ready_o=1 only on the two last_o cycles after the first load; empty_o never 1 between words.
REQ-033 SHALL cover: load 0xA5, drop out_ready_i for 3 cycles after the 2nd bit -> serial_o/last_o frozen at bit 2 value 1; the sequence resumes 0,0,1,0,1 with no bit lost or duplicated.
REQ-034 SHALL cover: in_valid_i=1 with 0xFF pulsed mid-word while 0x01 is shifting -> 0xFF ignored, output stays 1,0,0,0,0,0,0,0.
REQ-035 SHALL cover: assert reset after the 3rd bit of 0xFF -> outputs go to 0/empty_o=1 without waiting for clk; after release, load 0x81 -> full 1,0,0,0,0,0,0,1 emitted.
